bzone_input_cond: RTL and testbench
===================================

BZONE_INPUT_COND -- requirements
Module: bzone_input_cond

Interface
REQ-001 Parameter COIN_PULSE_CYCLES, default 1250000, coin-active pulse length in clk_sys cycles (50 ms @ 25 MHz).
REQ-002 Parameter COIN_HOLDOFF_CYCLES, default 2500000, post-pulse lockout in clk_sys cycles (100 ms).
REQ-003 clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scancode.
REQ-006 joy  in  16  active-high: [0] right, [1] left, [4] fire, [5] thrust, [6] shield, [7] coin, [8] start1, [9] start2; other bits ignored.
REQ-007 buttons_n  out  8  registered, active-low {right, left, start1, start2, fire, coin, thrust, shield}, MSB first.
REQ-008 coin_event  out  1  one-cycle strobe on each accepted coin.

Function
REQ-009 A key event SHALL be detected when ps2_key[10] differs from its value registered on the previous edge; no event on the first cycle after reset.
REQ-010 Each physical key SHALL have its own latch, set to ps2_key[9] on its event; unmapped scancodes leave all latches unchanged.
REQ-011 Map: 0x3A,0x14 fire; 0x05,0x16 start1; 0x06,0x1E start2; 0x1C,0x6B left; 0x23,0x74 right; 0x04,0x2E,0x36 coin; 0x4B,0x11 thrust; 0x42,0x29 shield.
REQ-012 Raw button = OR of its key latches OR its registered joy bit; releasing one of two held keys SHALL NOT release the button.
REQ-013 joy SHALL be registered once before use.
REQ-014 Latency: a key event or joy change on edge k SHALL appear on buttons_n after edge k+1.
REQ-015 Left and right both raw-active SHALL drive both low (no priority masking).
REQ-016 Coin FSM states IDLE, PULSE, HOLDOFF, WAIT_REL; coin bit of buttons_n low only in PULSE.
REQ-017 IDLE→PULSE on raw coin 0→1 edge; coin_event high for that one cycle; counter loaded.
REQ-018 PULSE lasts exactly COIN_PULSE_CYCLES cycles regardless of raw coin, then →HOLDOFF.
REQ-019 HOLDOFF lasts exactly COIN_HOLDOFF_CYCLES cycles, ignoring raw coin, then →WAIT_REL.
REQ-020 WAIT_REL→IDLE when raw coin is 0; a held coin SHALL NOT retrigger.
REQ-021 Counter width = clog2(max(COIN_PULSE_CYCLES, COIN_HOLDOFF_CYCLES)+1); counts down, no wrap.
REQ-022 A key event and joy change on the same edge SHALL both take effect.

Reset
REQ-023 On reset: all key latches 0, registered joy 0, toggle register loaded from ps2_key[10], FSM IDLE, counter 0, buttons_n 8'hFF, coin_event 0.
REQ-024 Reset asserted mid-PULSE or mid-HOLDOFF SHALL abort to IDLE with coin bit high on the next edge.
REQ-025 After reset release a coin already held SHALL NOT trigger until it is released and pressed again (raw-coin edge register reset to 1).

Structure
REQ-026 Package bzone_input_pkg: scancode constants, buttons_n bit-index constants, coin FSM state enum.
REQ-027 Sub-module bzone_coin_shaper (FSM + counter, REQ-016..021); the rest lives in bzone_input_cond.

Verification (COIN_PULSE_CYCLES=4, COIN_HOLDOFF_CYCLES=6)
REQ-028 Reset → buttons_n=8'hFF; toggle ps2_key with 0x23 pressed at edge k → buttons_n=8'h7F after edge k+1.
REQ-029 Press 0x3A, press 0x14, release 0x3A → bit3 stays 0; release 0x14 → bit3=1 after 2 edges.
REQ-030 joy[7] held 20 cycles → coin bit low exactly 4 cycles, one coin_event, no second pulse; release then repress after lockout → second pulse.
REQ-031 Coin repressed during HOLDOFF → ignored; coin_event count remains 1.
REQ-032 Reset at cycle 2 of PULSE → coin bit 1 next edge, FSM IDLE; held coin does not retrigger until released.
REQ-033 Unmapped scancode 0x55 events plus same-edge joy[0] rise → only bit7 goes low.

Source files
------------

// File: rtl/bzone_input_pkg.sv
// rtl/bzone_input_pkg.sv - scancode map, button bit positions and coin FSM states
package bzone_input_pkg;

  // PS/2 set-2 scancodes, two or three physical keys per button
  localparam logic [7:0] SC_FIRE_A    = 8'h3A;
  localparam logic [7:0] SC_FIRE_B    = 8'h14;
  localparam logic [7:0] SC_START1_A  = 8'h05;
  localparam logic [7:0] SC_START1_B  = 8'h16;
  localparam logic [7:0] SC_START2_A  = 8'h06;
  localparam logic [7:0] SC_START2_B  = 8'h1E;
  localparam logic [7:0] SC_LEFT_A    = 8'h1C;
  localparam logic [7:0] SC_LEFT_B    = 8'h6B;
  localparam logic [7:0] SC_RIGHT_A   = 8'h23;
  localparam logic [7:0] SC_RIGHT_B   = 8'h74;
  localparam logic [7:0] SC_COIN_A    = 8'h04;
  localparam logic [7:0] SC_COIN_B    = 8'h2E;
  localparam logic [7:0] SC_COIN_C    = 8'h36;
  localparam logic [7:0] SC_THRUST_A  = 8'h4B;
  localparam logic [7:0] SC_THRUST_B  = 8'h11;
  localparam logic [7:0] SC_SHIELD_A  = 8'h42;
  localparam logic [7:0] SC_SHIELD_B  = 8'h29;

  // bit positions inside buttons_n
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_START1 = 5;
  localparam int BTN_START2 = 4;
  localparam int BTN_FIRE   = 3;
  localparam int BTN_COIN   = 2;
  localparam int BTN_THRUST = 1;
  localparam int BTN_SHIELD = 0;

  // joystick bit positions
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_THRUST = 5;
  localparam int JOY_SHIELD = 6;
  localparam int JOY_COIN   = 7;
  localparam int JOY_START1 = 8;
  localparam int JOY_START2 = 9;

  localparam int          NUM_KEYS = 17;
  localparam logic [4:0]  KEY_NONE = 5'd31;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_HOLDOFF,
    COIN_WAIT_REL
  } coin_state_t;

  // latch slot of each physical key; keys of one button occupy adjacent slots
  function automatic logic [4:0] key_slot(input logic [7:0] sc);
    case (sc)
      SC_FIRE_A:   key_slot = 5'd0;
      SC_FIRE_B:   key_slot = 5'd1;
      SC_START1_A: key_slot = 5'd2;
      SC_START1_B: key_slot = 5'd3;
      SC_START2_A: key_slot = 5'd4;
      SC_START2_B: key_slot = 5'd5;
      SC_LEFT_A:   key_slot = 5'd6;
      SC_LEFT_B:   key_slot = 5'd7;
      SC_RIGHT_A:  key_slot = 5'd8;
      SC_RIGHT_B:  key_slot = 5'd9;
      SC_COIN_A:   key_slot = 5'd10;
      SC_COIN_B:   key_slot = 5'd11;
      SC_COIN_C:   key_slot = 5'd12;
      SC_THRUST_A: key_slot = 5'd13;
      SC_THRUST_B: key_slot = 5'd14;
      SC_SHIELD_A: key_slot = 5'd15;
      SC_SHIELD_B: key_slot = 5'd16;
      default:     key_slot = KEY_NONE;
    endcase
  endfunction

  // which latch slots feed each buttons_n bit
  function automatic logic [NUM_KEYS-1:0] btn_key_mask(input int btn);
    case (btn)
      BTN_RIGHT:  btn_key_mask = 17'h00300;
      BTN_LEFT:   btn_key_mask = 17'h000C0;
      BTN_START1: btn_key_mask = 17'h0000C;
      BTN_START2: btn_key_mask = 17'h00030;
      BTN_FIRE:   btn_key_mask = 17'h00003;
      BTN_COIN:   btn_key_mask = 17'h01C00;
      BTN_THRUST: btn_key_mask = 17'h06000;
      BTN_SHIELD: btn_key_mask = 17'h18000;
      default:    btn_key_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/bzone_coin_shaper.sv
// rtl/bzone_coin_shaper.sv - coin debounce: fixed-length pulse, lockout, then wait for release
module bzone_coin_shaper
  import bzone_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES   = 1250000,
  parameter int COIN_HOLDOFF_CYCLES = 2500000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw_coin,
  output logic coin_pulse,
  output logic coin_event
);

  localparam int MAX_CYCLES = (COIN_PULSE_CYCLES > COIN_HOLDOFF_CYCLES) ?
                              COIN_PULSE_CYCLES : COIN_HOLDOFF_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  coin_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              coin_prev;
  logic              settled;

  // coin_prev is held at 1 for the first cycle after reset because the
  // registered joy bit is still cleared then and would fake a 0->1 edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= COIN_IDLE;
      cnt        <= '0;
      coin_prev  <= 1'b1;
      settled    <= 1'b0;
      coin_pulse <= 1'b0;
      coin_event <= 1'b0;
    end else begin
      settled    <= 1'b1;
      coin_prev  <= settled ? raw_coin : 1'b1;
      coin_event <= 1'b0;
      case (state)
        COIN_IDLE: begin
          if (raw_coin && !coin_prev) begin
            state      <= COIN_PULSE;
            cnt        <= CNT_W'(COIN_PULSE_CYCLES - 1);
            coin_pulse <= 1'b1;
            coin_event <= 1'b1;
          end
        end
        COIN_PULSE: begin
          if (cnt == '0) begin
            state      <= COIN_HOLDOFF;
            cnt        <= CNT_W'(COIN_HOLDOFF_CYCLES - 1);
            coin_pulse <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COIN_HOLDOFF: begin
          if (cnt == '0) begin
            state <= COIN_WAIT_REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COIN_WAIT_REL: begin
          if (!raw_coin) begin
            state <= COIN_IDLE;
          end
        end
        default: begin
          state      <= COIN_IDLE;
          coin_pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bzone_input_cond.sv
// rtl/bzone_input_cond.sv - PS/2 key latches and joystick merge into active-low cabinet buttons
module bzone_input_cond
  import bzone_input_pkg::*;
#(
  parameter int COIN_PULSE_CYCLES   = 1250000,
  parameter int COIN_HOLDOFF_CYCLES = 2500000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  output logic [7:0]  buttons_n,
  output logic        coin_event
);

  logic                toggle_q;
  logic [NUM_KEYS-1:0] key_latch;
  logic [7:0]          joy_q;
  logic [7:0]          raw;
  logic [4:0]          hi_n_q;
  logic [1:0]          lo_n_q;
  logic                coin_pulse;
  logic                key_event;
  logic [4:0]          slot;
  logic                unused_bits;

  assign key_event   = ps2_key[10] ^ toggle_q;
  assign slot        = key_slot(ps2_key[7:0]);
  assign unused_bits = ^{joy[15:10], joy[3:2], ps2_key[8]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q  <= ps2_key[10];
      key_latch <= '0;
      joy_q     <= '0;
      hi_n_q    <= '1;
      lo_n_q    <= '1;
    end else begin
      toggle_q <= ps2_key[10];
      // joy_q is kept in buttons_n bit order so it lines up with raw[]
      joy_q    <= {joy[JOY_RIGHT], joy[JOY_LEFT], joy[JOY_START1], joy[JOY_START2],
                   joy[JOY_FIRE], joy[JOY_COIN], joy[JOY_THRUST], joy[JOY_SHIELD]};
      if (key_event && (slot != KEY_NONE)) begin
        key_latch[slot] <= ps2_key[9];
      end
      hi_n_q <= ~raw[7:3];
      lo_n_q <= ~raw[1:0];
    end
  end

  // left and right are deliberately not mutually masked
  always_comb begin
    raw = '0;
    for (int b = 0; b < 8; b++) begin
      raw[b] = (|(key_latch & btn_key_mask(b))) | joy_q[b];
    end
  end

  bzone_coin_shaper #(
    .COIN_PULSE_CYCLES   (COIN_PULSE_CYCLES),
    .COIN_HOLDOFF_CYCLES (COIN_HOLDOFF_CYCLES)
  ) u_coin (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .raw_coin   (raw[BTN_COIN]),
    .coin_pulse (coin_pulse),
    .coin_event (coin_event)
  );

  assign buttons_n = {hi_n_q, ~coin_pulse, lo_n_q};

endmodule

// File: tb/tb_bzone_input_cond.sv
// tb/tb_bzone_input_cond.sv - scoreboard bench with a cycle-stamped reference model
module tb_bzone_input_cond;

  localparam int P = 4;
  localparam int H = 6;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy     = '0;
  logic [7:0]  buttons_n;
  logic        coin_event;

  bzone_input_cond #(
    .COIN_PULSE_CYCLES   (P),
    .COIN_HOLDOFF_CYCLES (H)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joy        (joy),
    .buttons_n  (buttons_n),
    .coin_event (coin_event)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         edge_no;
    logic [7:0] bn;
    logic       ce;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  int    mon_edges = 0;
  int    act_coin  = 0;
  int    exp_coin  = 0;

  // reference model state: what each key and joy bit currently holds
  int         btn_of_sc [256];
  int         joy_of_btn [8];
  bit         held [256];
  logic       m_tog;
  logic [15:0] m_jq;
  bit [7:0]   m_raw;
  int         accept_edge;
  bit         m_prev;
  bit         m_settled;
  int         drv_edge = 0;

  logic [7:0] mapped_sc [17] = '{8'h3A, 8'h14, 8'h05, 8'h16, 8'h06, 8'h1E, 8'h1C, 8'h6B,
                                 8'h23, 8'h74, 8'h04, 8'h2E, 8'h36, 8'h4B, 8'h11, 8'h42, 8'h29};

  always @(posedge clk_sys) mon_edges <= mon_edges + 1;

  always @(negedge clk_sys) begin
    exp_t  e;
    string t;
    if (coin_event === 1'b1) act_coin++;
    while (exp_q.size() > 0 && exp_q[0].edge_no <= mon_edges) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (buttons_n !== e.bn || coin_event !== e.ce) begin
        bad++;
        $display("FAIL %s edge=%0d: buttons_n=%h coin_event=%b, required buttons_n=%h coin_event=%b",
                 t, e.edge_no, buttons_n, coin_event, e.bn, e.ce);
      end
    end
  end

  function automatic bit [7:0] raw_of();
    bit [7:0] r;
    r = '0;
    for (int s = 0; s < 256; s++)
      if (btn_of_sc[s] >= 0 && held[s]) r[btn_of_sc[s]] = 1'b1;
    for (int b = 0; b < 8; b++)
      if (m_jq[joy_of_btn[b]] === 1'b1) r[b] = 1'b1;
    return r;
  endfunction

  // Inputs are already driven; predict the outputs after the coming edge.
  task automatic step(input string tag);
    exp_t     e;
    bit [7:0] raw_cur;
    bit       coin_low;
    bit       ce;
    drv_edge++;
    ce = 1'b0;
    if (reset) begin
      for (int s = 0; s < 256; s++) held[s] = 1'b0;
      m_tog       = ps2_key[10];
      m_jq        = '0;
      m_raw       = '0;
      accept_edge = -1;
      m_prev      = 1'b1;
      m_settled   = 1'b0;
      e.bn        = 8'hFF;
    end else begin
      raw_cur = m_raw;
      if (accept_edge < 0) begin
        if (raw_cur[2] && !m_prev) begin
          accept_edge = drv_edge;
          ce = 1'b1;
          exp_coin++;
        end
      end else if ((drv_edge - accept_edge) > P + H && !raw_cur[2]) begin
        accept_edge = -1;
      end
      coin_low  = (accept_edge >= 0) && ((drv_edge - accept_edge) < P);
      m_prev    = m_settled ? raw_cur[2] : 1'b1;
      m_settled = 1'b1;
      e.bn      = ~raw_cur;
      e.bn[2]   = ~coin_low;
      if (ps2_key[10] != m_tog && btn_of_sc[ps2_key[7:0]] >= 0)
        held[ps2_key[7:0]] = ps2_key[9];
      m_tog = ps2_key[10];
      m_jq  = joy;
      m_raw = raw_of();
    end
    e.edge_no = drv_edge;
    e.ce      = ce;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic hold(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_key(input logic [7:0] sc, input logic pressed);
    logic ext;
    ext = 1'($urandom_range(0, 1));
    ps2_key = {~ps2_key[10], pressed, ext, sc};
  endtask

  task automatic key_ev(input logic [7:0] sc, input logic pressed, input string tag);
    set_key(sc, pressed);
    step(tag);
  endtask

  initial begin
    int         r;
    logic [7:0] sc;
    int         idx;

    for (int s = 0; s < 256; s++) btn_of_sc[s] = -1;
    btn_of_sc[8'h3A] = 3; btn_of_sc[8'h14] = 3;
    btn_of_sc[8'h05] = 5; btn_of_sc[8'h16] = 5;
    btn_of_sc[8'h06] = 4; btn_of_sc[8'h1E] = 4;
    btn_of_sc[8'h1C] = 6; btn_of_sc[8'h6B] = 6;
    btn_of_sc[8'h23] = 7; btn_of_sc[8'h74] = 7;
    btn_of_sc[8'h04] = 2; btn_of_sc[8'h2E] = 2; btn_of_sc[8'h36] = 2;
    btn_of_sc[8'h4B] = 1; btn_of_sc[8'h11] = 1;
    btn_of_sc[8'h42] = 0; btn_of_sc[8'h29] = 0;
    joy_of_btn[7] = 0; joy_of_btn[6] = 1; joy_of_btn[5] = 8; joy_of_btn[4] = 9;
    joy_of_btn[3] = 4; joy_of_btn[2] = 7; joy_of_btn[1] = 5; joy_of_btn[0] = 6;

    reset = 1'b1;
    hold(2, "reset_state");
    reset = 1'b0;
    hold(2, "idle_after_reset");

    key_ev(8'h23, 1'b1, "right_press");
    hold(3, "right_held");
    key_ev(8'h23, 1'b0, "right_release");
    hold(2, "right_released");

    key_ev(8'h3A, 1'b1, "fire_a_press");
    key_ev(8'h14, 1'b1, "fire_b_press");
    key_ev(8'h3A, 1'b0, "fire_a_release");
    hold(2, "fire_b_still_held");
    key_ev(8'h14, 1'b0, "fire_b_release");
    hold(3, "fire_released");

    joy[7] = 1'b1;
    hold(20, "coin_held");
    joy[7] = 1'b0;
    hold(3, "coin_released");
    joy[7] = 1'b1;
    hold(15, "coin_second");
    joy[7] = 1'b0;
    hold(3, "coin_second_released");

    joy[7] = 1'b1;
    hold(2, "coin_third");
    joy[7] = 1'b0;
    hold(5, "coin_third_short");
    joy[7] = 1'b1;
    hold(2, "coin_in_holdoff");
    joy[7] = 1'b0;
    hold(8, "coin_holdoff_expire");

    joy[7] = 1'b1;
    hold(3, "coin_before_reset");
    reset = 1'b1;
    step("reset_mid_pulse");
    reset = 1'b0;
    hold(15, "held_after_reset");
    joy[7] = 1'b0;
    hold(2, "release_after_reset");
    joy[7] = 1'b1;
    hold(12, "repress_after_reset");
    joy[7] = 1'b0;
    hold(2, "final_release");

    set_key(8'h55, 1'b1);
    joy[0] = 1'b1;
    step("unmapped_with_joy_right");
    hold(2, "unmapped_settle");
    key_ev(8'h55, 1'b0, "unmapped_release");
    joy[0] = 1'b0;
    joy[1] = 1'b1;
    key_ev(8'h23, 1'b1, "left_right_both");
    hold(2, "left_right_held");
    joy[1] = 1'b0;
    key_ev(8'h23, 1'b0, "left_right_clear");

    key_ev(8'h04, 1'b1, "coin_key_a");
    key_ev(8'h2E, 1'b1, "coin_key_b");
    key_ev(8'h04, 1'b0, "coin_key_a_release");
    hold(14, "coin_key_b_held");
    key_ev(8'h2E, 1'b0, "coin_key_b_release");
    hold(3, "coin_keys_idle");

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      reset = (r < 2);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) sc = 8'($urandom_range(0, 255));
        else sc = mapped_sc[$urandom_range(0, 16)];
        set_key(sc, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, 15);
        joy[idx] = ~joy[idx];
      end
      if ($urandom_range(0, 9) == 0) joy[7] = ~joy[7];
      step("random");
    end
    reset = 1'b0;
    hold(4, "random_tail");

    @(negedge clk_sys);
    @(negedge clk_sys);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    total++;
    if (act_coin != exp_coin) begin
      bad++;
      $display("FAIL coin_event_count: counted %0d, required %0d", act_coin, exp_coin);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
